// File: rtl/rv32_if_stage.sv
// rv32_if_stage: PC generation, single-outstanding instruction fetch and a small instruction FIFO.
// Define IF_MISALIGN_CHK_EN to halt fetch and flag misaligned redirect targets.
module rv32_if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_misalign
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             out_q, out_d;
    logic             discard_q, discard_d;
    logic             started_q, started_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      buf_instr_q [FIFO_DEPTH];
    logic [31:0]      buf_instr_d [FIFO_DEPTH];
    logic [31:0]      buf_pc_q    [FIFO_DEPTH];
    logic [31:0]      buf_pc_d    [FIFO_DEPTH];

    logic             halt;
    logic [31:0]      redir_pc;
    logic             rsp;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [31:0]      head_instr;
    logic [31:0]      head_pc;

    assign imem_req  = started_q & ~out_q & ~redirect_valid & ~halt & (count_q < DEPTH_C);
    assign imem_addr = pc_q;

    assign head_valid = (count_q != '0);
    assign head_instr = head_valid ? buf_instr_q[rd_ptr_q] : NOP_INSTR;
    assign head_pc    = head_valid ? buf_pc_q[rd_ptr_q] : 32'h0;

    // Redirect beats response handling, which beats the issue/pop bookkeeping.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        out_d       = out_q;
        discard_d   = discard_q;
        started_d   = 1'b1;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        rsp         = imem_rvalid & out_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = redir_pc;
            if (rsp) begin
                out_d     = 1'b0;
                discard_d = 1'b0;
            end else if (out_q) begin
                discard_d = 1'b1;
            end
        end else begin
            if (rsp) begin
                out_d = 1'b0;
                if (discard_q) begin
                    discard_d = 1'b0;
                end else begin
                    push = 1'b1;
                end
            end
            if (imem_req) begin
                out_d    = 1'b1;
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
            end
            pop = head_valid & id_ready;
            if (push) begin
                buf_instr_d[wr_ptr_q] = imem_rdata;
                buf_pc_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            out_q       <= 1'b0;
            discard_q   <= 1'b0;
            started_q   <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            buf_instr_q <= '{default: '0};
            buf_pc_q    <= '{default: '0};
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            out_q       <= out_d;
            discard_q   <= discard_d;
            started_q   <= started_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    logic        halt_q, halt_d;
    logic [31:0] halt_pc_q, halt_pc_d;

    // Any redirect re-evaluates the halt; only an aligned target resumes fetch.
    always_comb begin
        halt_d    = halt_q;
        halt_pc_d = halt_pc_q;
        if (redirect_valid) begin
            halt_d    = (redirect_pc[1:0] != 2'b00);
            halt_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q    <= 1'b0;
            halt_pc_q <= 32'h0;
        end else begin
            halt_q    <= halt_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    assign halt        = halt_q;
    assign redir_pc    = redirect_pc;
    assign if_valid    = halt_q | head_valid;
    assign if_instr    = halt_q ? NOP_INSTR : head_instr;
    assign if_pc       = halt_q ? halt_pc_q : head_pc;
    assign if_misalign = halt_q;
`else
    assign halt        = 1'b0;
    assign redir_pc    = redirect_pc & ~32'h3;
    assign if_valid    = head_valid;
    assign if_instr    = head_instr;
    assign if_pc       = head_pc;
    assign if_misalign = 1'b0;
`endif

endmodule
